sd_spi_slave: RTL and testbench

//  Synthesizable SPI-mode SD card emulator, clocked from the system clock; SPI pins oversampled.

---
 rtl/sd_spi_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_sd_spi_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_slave.sv
// sd_spi_slave: SPI-mode SD card emulator with one block buffer and a byte-wide req/ack memory port.
// SPI pins are oversampled on clk; all protocol decisions are taken at byte boundaries.
module sd_spi_slave #(
    parameter int BLK_LEN  = 512,
    parameter int ADR_W    = 32,
    parameter int BLK_ADDR = 1,
    parameter int NCR      = 1,
    parameter int IDLE_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sck,
    input  logic             ss,
    input  logic             mosi,
    output logic             miso,
    output logic             mem_req,
    output logic             mem_we,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_wdat,
    input  logic [7:0]       mem_rdat,
    input  logic             mem_ack
);
    localparam int LG = $clog2(BLK_LEN);
    localparam logic [LG-1:0] LAST = LG'(BLK_LEN - 1);
    localparam logic [31:0] OCR = BLK_ADDR != 0 ? 32'hC0FF_8000 : 32'h80FF_8000;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_NCR, S_RESP, S_RD_FILL, S_RD_TOK, S_RD_DATA, S_RD_CRC,
        S_WR_TOK, S_WR_DATA, S_WR_CRC, S_WR_DRESP, S_WR_BUSY
    } state_t;

    logic [2:0]       sck_q;
    logic [1:0]       ss_q, mosi_q;
    logic             ss_s, rise, fall, byte_done, load;
    logic [2:0]       bit_cnt;
    logic [7:0]       rx_sh, rx_byte, tx_sh, tx_byte;
    state_t           state, post;
    logic [5:0]       cmd;
    logic [31:0]      arg;
    logic [3:0]       cnt, resp_n;
    logic [39:0]      resp_q, resp;
    logic [7:0]       r1, acnt;
    logic             idle, acmd, is_a41, rw, legal, new_idle;
    logic [LG-1:0]    didx, m_cnt, buf_wa;
    logic [ADR_W-1:0] m_base, base;
    logic             m_run, m_wr, m_own, buf_we;
    logic [7:0]       buf_wd;
    logic [7:0]       buffer [BLK_LEN];

    assign miso = tx_sh[7];

    always_comb begin
        ss_s = ss_q[1];
        rise = sck_q[1] && !sck_q[2] && !ss_s;
        fall = !sck_q[1] && sck_q[2] && !ss_s;
        byte_done = rise && bit_cnt == 3'd7;
        rx_byte = {rx_sh[6:0], mosi_q[1]};
        is_a41 = acmd && cmd == 6'd41;
        rw = cmd == 6'd17 || cmd == 6'd24;
        legal = cmd == 6'd0 || cmd == 6'd8 || cmd == 6'd55 || cmd == 6'd58 || rw || is_a41;
        new_idle = cmd == 6'd0 ? 1'b1 : (is_a41 && acnt >= 8'(IDLE_CNT)) ? 1'b0 : idle;
        r1 = {5'b0, !legal || (rw && idle), 1'b0, new_idle};
        resp = cmd == 6'd8 ? {r1, 20'h0, arg[11:0]} : cmd == 6'd58 ? {r1, OCR} : {r1, 32'hFFFF_FFFF};
        resp_n = cmd == 6'd8 || cmd == 6'd58 ? 4'd4 : 4'd0;
        base = BLK_ADDR != 0 ? ADR_W'(arg) << LG : ADR_W'(arg);
        buf_we = (byte_done && state == S_WR_DATA) || (mem_req && mem_ack && m_own && !mem_we);
        buf_wa = byte_done && state == S_WR_DATA ? didx : m_cnt;
        buf_wd = byte_done && state == S_WR_DATA ? rx_byte : mem_rdat;
    end

    always_ff @(posedge clk)
        if (buf_we) buffer[buf_wa] <= buf_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q <= '0;
            ss_q <= '1;
            mosi_q <= '1;
            bit_cnt <= '0;
            rx_sh <= '0;
            tx_sh <= 8'hFF;
            tx_byte <= 8'hFF;
            load <= 1'b0;
            state <= S_IDLE;
            post <= S_IDLE;
            cmd <= '0;
            arg <= '0;
            cnt <= '0;
            resp_q <= '0;
            idle <= 1'b1;
            acmd <= 1'b0;
            acnt <= '0;
            didx <= '0;
            m_cnt <= '0;
            m_base <= '0;
            m_run <= 1'b0;
            m_wr <= 1'b0;
            m_own <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_adr <= '0;
            mem_wdat <= '0;
        end else begin
            sck_q <= {sck_q[1:0], sck};
            ss_q <= {ss_q[0], ss};
            mosi_q <= {mosi_q[0], mosi};
            // m_own marks a request issued by the current transfer; orphans left by an abort are just retired
            if (mem_req) begin
                if (mem_ack) begin
                    mem_req <= 1'b0;
                    m_own <= 1'b0;
                    if (m_own) begin
                        if (m_cnt == LAST) m_run <= 1'b0;
                        else m_cnt <= m_cnt + 1'b1;
                    end
                end
            end else if (m_run) begin
                mem_req <= 1'b1;
                mem_we <= m_wr;
                mem_adr <= m_base + ADR_W'(m_cnt);
                mem_wdat <= buffer[m_cnt];
                m_own <= 1'b1;
            end
            if (rise) begin
                rx_sh <= rx_byte;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (fall) begin
                tx_sh <= load ? tx_byte : {tx_sh[6:0], 1'b1};
                load <= 1'b0;
            end
            if (byte_done) begin
                load <= 1'b1;
                tx_byte <= 8'hFF;
                case (state)
                    S_IDLE: if (rx_byte[7:6] == 2'b01) begin
                        cmd <= rx_byte[5:0];
                        cnt <= '0;
                        state <= S_CMD;
                    end
                    S_CMD: if (cnt != 4'd4) begin
                        arg <= {arg[23:0], rx_byte};
                        cnt <= cnt + 1'b1;
                    end else begin
                        idle <= new_idle;
                        acmd <= cmd == 6'd55;
                        acnt <= cmd == 6'd0 ? 8'd0 : (is_a41 && acnt < 8'(IDLE_CNT)) ? acnt + 1'b1 : acnt;
                        resp_q <= resp;
                        post <= rw && !idle ? (cmd == 6'd17 ? S_RD_FILL : S_WR_TOK) : S_IDLE;
                        m_base <= base;
                        cnt <= '0;
                        state <= S_NCR;
                    end
                    S_NCR: if (cnt == 4'(NCR - 1)) begin
                        tx_byte <= resp_q[39:32];
                        resp_q <= {resp_q[31:0], 8'h00};
                        cnt <= resp_n;
                        state <= S_RESP;
                    end else cnt <= cnt + 1'b1;
                    S_RESP: if (cnt == '0) begin
                        state <= post;
                        if (post == S_RD_FILL) begin
                            m_run <= 1'b1;
                            m_wr <= 1'b0;
                            m_cnt <= '0;
                        end
                    end else begin
                        tx_byte <= resp_q[39:32];
                        resp_q <= {resp_q[31:0], 8'h00};
                        cnt <= cnt - 1'b1;
                    end
                    S_RD_FILL: if (!m_run) begin
                        tx_byte <= 8'hFE;
                        state <= S_RD_TOK;
                    end
                    S_RD_TOK: begin
                        tx_byte <= buffer[0];
                        didx <= '0;
                        state <= S_RD_DATA;
                    end
                    S_RD_DATA: if (didx == LAST) begin
                        cnt <= '0;
                        state <= S_RD_CRC;
                    end else begin
                        tx_byte <= buffer[didx + 1'b1];
                        didx <= didx + 1'b1;
                    end
                    S_RD_CRC: if (cnt == 4'd1) state <= S_IDLE;
                        else cnt <= cnt + 1'b1;
                    S_WR_TOK: begin
                        didx <= '0;
                        state <= rx_byte == 8'hFE ? S_WR_DATA : rx_byte == 8'hFF ? S_WR_TOK : S_IDLE;
                    end
                    S_WR_DATA: if (didx == LAST) begin
                        cnt <= '0;
                        state <= S_WR_CRC;
                    end else didx <= didx + 1'b1;
                    S_WR_CRC: if (cnt == 4'd1) begin
                        tx_byte <= 8'h05;
                        state <= S_WR_DRESP;
                        m_run <= 1'b1;
                        m_wr <= 1'b1;
                        m_cnt <= '0;
                    end else cnt <= cnt + 1'b1;
                    S_WR_DRESP: begin
                        tx_byte <= 8'h00;
                        state <= S_WR_BUSY;
                    end
                    S_WR_BUSY: if (m_run) tx_byte <= 8'h00;
                        else state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
            if (ss_s) begin
                bit_cnt <= '0;
                tx_sh <= 8'hFF;
                load <= 1'b0;
                state <= S_IDLE;
                m_run <= 1'b0;
                m_own <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_slave.sv
// tb_sd_spi_slave: directed bench for sd_spi_slave; init sequence, R7/R3, block read/write, ss abort.
module tb_sd_spi_slave;
    logic        clk = 1'b0, rst = 1'b1, sck = 1'b0, ss = 1'b1, mosi = 1'b1;
    logic        miso, mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_adr;
    logic [7:0]  mem_wdat;
    logic [7:0]  mem_rdat = 8'h00;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] rd_log [$];
    logic [31:0] wr_adr_log [$];
    logic [7:0]  wr_dat_log [$];

    sd_spi_slave dut (
        .clk(clk), .rst(rst), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
        .mem_rdat(mem_rdat), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // memory returns adr[7:0] on reads and logs every access
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_req && !mem_ack) begin
            mem_ack = 1'b1;
            mem_rdat = mem_adr[7:0];
            if (mem_we) begin
                wr_adr_log.push_back(mem_adr);
                wr_dat_log.push_back(mem_wdat);
            end else rd_log.push_back(mem_adr);
        end else mem_ack = 1'b0;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #40;
            rx[i] = miso;
            sck = 1'b1;
            #40;
            sck = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] a, input logic [7:0] crc,
                            output logic [7:0] r1);
        logic [7:0] d;
        xfer({2'b01, idx}, d);
        for (int i = 3; i >= 0; i--) xfer(a[i*8 +: 8], d);
        xfer(crc, d);
        xfer(8'hFF, d);
        check("ncr_ff", {24'h0, d}, 32'hFF);
        xfer(8'hFF, r1);
    endtask

    task automatic read4(output logic [31:0] w);
        logic [7:0] d;
        for (int i = 3; i >= 0; i--) begin
            xfer(8'hFF, d);
            w[i*8 +: 8] = d;
        end
    endtask

    task automatic wait_token(output logic [7:0] d);
        int k;
        k = 0;
        d = 8'hFF;
        while (d == 8'hFF && k < 64) begin
            xfer(8'hFF, d);
            k++;
        end
    endtask

    initial begin
        logic [7:0]  r, d;
        logic [31:0] w;
        int          start, bad, zeros, k;
        repeat (4) @(negedge clk);
        check("rst_miso", {31'h0, miso}, 32'h1);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_adr", mem_adr, 32'h0);
        check("rst_mem_wdat", {24'h0, mem_wdat}, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        ss = 1'b0;
        repeat (4) @(negedge clk);

        send_cmd(6'd0, 32'h0, 8'h95, r);
        check("cmd0_r1", {24'h0, r}, 32'h01);
        send_cmd(6'd8, 32'h0000_01AA, 8'h87, r);
        check("cmd8_r1", {24'h0, r}, 32'h01);
        read4(w);
        check("cmd8_r7", w, 32'h0000_01AA);
        for (int i = 0; i < 3; i++) begin
            send_cmd(6'd55, 32'h0, 8'hFF, r);
            check("cmd55_r1", {24'h0, r}, 32'h01);
            send_cmd(6'd41, 32'h4000_0000, 8'hFF, r);
            check("acmd41_r1", {24'h0, r}, i < 2 ? 32'h01 : 32'h00);
        end
        send_cmd(6'd58, 32'h0, 8'hFF, r);
        check("cmd58_r1", {24'h0, r}, 32'h00);
        read4(w);
        check("cmd58_ocr", w, 32'hC0FF_8000);

        start = rd_log.size();
        send_cmd(6'd17, 32'd3, 8'hFF, r);
        check("cmd17_r1", {24'h0, r}, 32'h00);
        wait_token(d);
        check("rd_token", {24'h0, d}, 32'hFE);
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            xfer(8'hFF, d);
            if (d !== i[7:0]) bad++;
        end
        check("rd_data_bad", bad, 0);
        xfer(8'hFF, d);
        check("rd_crc0", {24'h0, d}, 32'hFF);
        xfer(8'hFF, d);
        check("rd_crc1", {24'h0, d}, 32'hFF);
        check("rd_count", rd_log.size() - start, 512);
        bad = 0;
        for (int i = 0; i < 512 && start + i < rd_log.size(); i++)
            if (rd_log[start + i] !== 32'(1536 + i)) bad++;
        check("rd_adr_bad", bad, 0);

        start = wr_adr_log.size();
        send_cmd(6'd24, 32'd1, 8'hFF, r);
        check("cmd24_r1", {24'h0, r}, 32'h00);
        xfer(8'hFF, d);
        xfer(8'hFE, d);
        repeat (512) xfer(8'hA5, d);
        xfer(8'h12, d);
        xfer(8'h34, d);
        xfer(8'hFF, d);
        check("wr_dresp", {24'h0, d}, 32'h05);
        k = 0;
        bad = 0;
        zeros = 0;
        xfer(8'hFF, d);
        while (d != 8'hFF && k < 64) begin
            if (d == 8'h00) zeros++;
            else bad++;
            xfer(8'hFF, d);
            k++;
        end
        check("wr_busy_end", {24'h0, d}, 32'hFF);
        check("wr_busy_bad", bad, 0);
        check("wr_busy_seen", {31'h0, zeros > 0}, 32'h1);
        check("wr_count", wr_adr_log.size() - start, 512);
        bad = 0;
        for (int i = 0; i < 512 && start + i < wr_adr_log.size(); i++)
            if (wr_adr_log[start + i] !== 32'(512 + i) || wr_dat_log[start + i] !== 8'hA5) bad++;
        check("wr_access_bad", bad, 0);

        send_cmd(6'd17, 32'd3, 8'hFF, r);
        check("abort_r1", {24'h0, r}, 32'h00);
        wait_token(d);
        check("abort_token", {24'h0, d}, 32'hFE);
        repeat (100) xfer(8'hFF, d);
        ss = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_miso", {31'h0, miso}, 32'h1);
        ss = 1'b0;
        repeat (4) @(negedge clk);
        send_cmd(6'd0, 32'h0, 8'h95, r);
        check("abort_cmd0_r1", {24'h0, r}, 32'h01);
        start = rd_log.size();
        send_cmd(6'd17, 32'd3, 8'hFF, r);
        check("cmd17_idle_r1", {24'h0, r}, 32'h05);
        xfer(8'hFF, d);
        check("cmd17_idle_nodata", {24'h0, d}, 32'hFF);
        repeat (20) @(negedge clk);
        check("cmd17_idle_noread", rd_log.size() - start, 0);
        check("end_mem_req", {31'h0, mem_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
